// File: rtl/surf_mem_pkg.sv
// Shared types and widths for the SURF input-image memory arbiter.
package surf_mem_pkg;

    localparam int IMG_ADDR_W = 17;
    localparam int IMG_DATA_W = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } rsp_tag_t;

endpackage

// File: rtl/surf_rsp_tag_pipe.sv
// Shift register of response tags; the last stage lines up with BRAM read data.
module surf_rsp_tag_pipe
    import surf_mem_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  rsp_tag_t tag_in,
    output rsp_tag_t tag_out
);

    rsp_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/surf_img_mem_arbiter.sv
// Round-robin arbiter sharing the image BRAM port between the descriptor
// fetch engine (requester 0) and the AXI-Lite loader/debug path (requester 1).
//
// state | meaning
// IDLE  | no owner; winner (sole valid, or rr on a tie) is accepted this cycle
// OWN0  | requester 0 holds the port for the rest of its burst
// OWN1  | requester 1 holds the port for the rest of its burst
module surf_img_mem_arbiter
    import surf_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = IMG_ADDR_W,
    parameter int DATA_WIDTH = IMG_DATA_W,
    parameter int RD_LATENCY = 2,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_we_0,
    input  logic                  req_last_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_data_0,

    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_we_1,
    input  logic                  req_last_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_data_1,

    output logic                  img_ena,
    output logic                  img_wea,
    output logic [ADDR_WIDTH-1:0] img_addra,
    output logic [DATA_WIDTH-1:0] img_dina,
    input  logic [DATA_WIDTH-1:0] img_douta
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t            state, state_nxt;
    logic                  rr, rr_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_inc;
    logic                  sel;
    logic                  acc;
    logic                  beat_valid;
    logic                  beat_last;
    logic                  beat_we;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [DATA_WIDTH-1:0] beat_wdata;
    rsp_tag_t              tag_push;
    rsp_tag_t              tag_out;

    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr;
        cnt_nxt     = cnt;
        sel         = 1'b0;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;

        case (state)
            IDLE: begin
                sel         = (req_valid_0 && req_valid_1) ? rr : req_valid_1;
                req_ready_0 = req_valid_0 && !sel;
                req_ready_1 = req_valid_1 && sel;
            end
            OWN0: begin
                sel         = 1'b0;
                req_ready_0 = 1'b1;
            end
            OWN1: begin
                sel         = 1'b1;
                req_ready_1 = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // Nothing may be accepted while reset is asserted.
        if (!rst) begin
            req_ready_0 = 1'b0;
            req_ready_1 = 1'b0;
        end

        beat_valid = sel ? req_valid_1 : req_valid_0;
        beat_last  = sel ? req_last_1  : req_last_0;
        beat_we    = sel ? req_we_1    : req_we_0;
        beat_addr  = sel ? req_addr_1  : req_addr_0;
        beat_wdata = sel ? req_wdata_1 : req_wdata_0;
        acc        = beat_valid && (sel ? req_ready_1 : req_ready_0);
        cnt_inc    = cnt + 1'b1;

        if (state != IDLE && !beat_valid) begin
            state_nxt = IDLE;
            rr_nxt    = !sel;
            cnt_nxt   = '0;
        end else if (acc) begin
            if (beat_last || cnt_inc == CNT_MAX) begin
                state_nxt = IDLE;
                rr_nxt    = !sel;
                cnt_nxt   = '0;
            end else begin
                state_nxt = sel ? OWN1 : OWN0;
                cnt_nxt   = cnt_inc;
            end
        end

        tag_push       = '0;
        tag_push.valid = acc && !beat_we;
        tag_push.id    = sel;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rr        <= 1'b0;
            cnt       <= '0;
            img_ena   <= 1'b0;
            img_wea   <= 1'b0;
            img_addra <= '0;
            img_dina  <= '0;
        end else begin
            state   <= state_nxt;
            rr      <= rr_nxt;
            cnt     <= cnt_nxt;
            img_ena <= acc;
            img_wea <= acc && beat_we;
            if (acc) begin
                img_addra <= beat_addr;
                img_dina  <= beat_wdata;
            end
        end
    end

    // One extra stage covers the img_ena register ahead of the BRAM latency.
    surf_rsp_tag_pipe #(
        .DEPTH (RD_LATENCY + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_push),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_data_0  <= '0;
            rsp_data_1  <= '0;
        end else begin
            rsp_valid_0 <= tag_out.valid && !tag_out.id;
            rsp_valid_1 <= tag_out.valid && tag_out.id;
            if (tag_out.valid && !tag_out.id) begin
                rsp_data_0 <= img_douta;
            end
            if (tag_out.valid && tag_out.id) begin
                rsp_data_1 <= img_douta;
            end
        end
    end

endmodule

// File: tb/tb_surf_img_mem_arbiter.sv
// Scoreboard bench for surf_img_mem_arbiter with a write-first 2-cycle BRAM model.
module tb_surf_img_mem_arbiter;

    localparam int RD_LAT = 2;

    typedef struct packed {
        logic        we;
        logic        last;
        logic [16:0] addr;
        logic [47:0] wdata;
    } beat_t;

    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [47:0] data;
        int          cyc;
    } img_op_t;

    typedef struct packed {
        logic [47:0] data;
        int          cyc;
    } rsp_exp_t;

    typedef struct packed {
        int cyc;
        int id;
    } acc_t;

    logic        clk;
    logic        rst;
    logic        req_valid_0, req_ready_0, req_we_0, req_last_0;
    logic [16:0] req_addr_0;
    logic [47:0] req_wdata_0;
    logic        rsp_valid_0;
    logic [47:0] rsp_data_0;
    logic        req_valid_1, req_ready_1, req_we_1, req_last_1;
    logic [16:0] req_addr_1;
    logic [47:0] req_wdata_1;
    logic        rsp_valid_1;
    logic [47:0] rsp_data_1;
    logic        img_ena, img_wea;
    logic [16:0] img_addra;
    logic [47:0] img_dina, img_douta;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int img_cnt = 0, wea_cnt = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
    bit mon_en = 0;
    bit en0 = 1, en1 = 1;

    beat_t    bq0[$], bq1[$];
    img_op_t  iq[$];
    rsp_exp_t rq0[$], rq1[$];
    acc_t     alog[$];

    logic [47:0] mem    [logic [16:0]];
    logic [47:0] shadow [logic [16:0]];
    logic [47:0] d1, d2;

    surf_img_mem_arbiter #(
        .ADDR_WIDTH (17),
        .DATA_WIDTH (48),
        .RD_LATENCY (RD_LAT),
        .MAX_BURST  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_0 (req_valid_0),
        .req_ready_0 (req_ready_0),
        .req_we_0    (req_we_0),
        .req_last_0  (req_last_0),
        .req_addr_0  (req_addr_0),
        .req_wdata_0 (req_wdata_0),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_data_0  (rsp_data_0),
        .req_valid_1 (req_valid_1),
        .req_ready_1 (req_ready_1),
        .req_we_1    (req_we_1),
        .req_last_1  (req_last_1),
        .req_addr_1  (req_addr_1),
        .req_wdata_1 (req_wdata_1),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_data_1  (rsp_data_1),
        .img_ena     (img_ena),
        .img_wea     (img_wea),
        .img_addra   (img_addra),
        .img_dina    (img_dina),
        .img_douta   (img_douta)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] dflt(input logic [16:0] a);
        return 48'hC0DE_0000_0000 | {31'd0, a};
    endfunction

    function automatic logic [47:0] mem_rd(input logic [16:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [47:0] shadow_rd(input logic [16:0] a);
        return shadow.exists(a) ? shadow[a] : dflt(a);
    endfunction

    // Write-first BRAM, RD_LAT cycles from img_ena to img_douta.
    always @(posedge clk) begin
        if (img_ena === 1'b1) begin
            if (img_wea === 1'b1) begin
                mem[img_addra] = img_dina;
                d1 <= img_dina;
            end else begin
                d1 <= mem_rd(img_addra);
            end
        end
        d2 <= d1;
    end
    assign img_douta = d2;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        img_op_t  op;
        rsp_exp_t e;
        if (mon_en) begin
            if (img_ena === 1'b1) begin
                img_cnt++;
                if (img_wea === 1'b1) wea_cnt++;
                chk("img_op_expected", iq.size() > 0, 1);
                if (iq.size() > 0) begin
                    op = iq.pop_front();
                    chk("img_cycle", cyc, op.cyc);
                    chk("img_we", img_wea, op.we);
                    chk("img_addr", img_addra, op.addr);
                    if (op.we) chk("img_din", img_dina, op.data);
                end
            end
            if (rsp_valid_0 === 1'b1) begin
                rsp_cnt0++;
                chk("rsp0_expected", rq0.size() > 0, 1);
                if (rq0.size() > 0) begin
                    e = rq0.pop_front();
                    chk("rsp0_cycle", cyc, e.cyc);
                    chk("rsp0_data", rsp_data_0, e.data);
                end
            end
            if (rsp_valid_1 === 1'b1) begin
                rsp_cnt1++;
                chk("rsp1_expected", rq1.size() > 0, 1);
                if (rq1.size() > 0) begin
                    e = rq1.pop_front();
                    chk("rsp1_cycle", cyc, e.cyc);
                    chk("rsp1_data", rsp_data_1, e.data);
                end
            end
        end
    end

    task automatic push_beat(input int id, input logic we, input logic last,
                             input logic [16:0] addr, input logic [47:0] wdata);
        beat_t b;
        b.we = we; b.last = last; b.addr = addr; b.wdata = wdata;
        if (id == 1) bq1.push_back(b);
        else         bq0.push_back(b);
    endtask

    task automatic add_burst(input int id, input int n, input logic [16:0] base);
        for (int i = 0; i < n; i++) begin
            push_beat(id, 1'b0, (i == n - 1), base + 17'(i), 48'(i));
        end
    endtask

    task automatic drive();
        req_valid_0 = en0 && bq0.size() > 0;
        req_valid_1 = en1 && bq1.size() > 0;
        if (bq0.size() > 0) begin
            req_we_0 = bq0[0].we; req_last_0 = bq0[0].last;
            req_addr_0 = bq0[0].addr; req_wdata_0 = bq0[0].wdata;
        end
        if (bq1.size() > 0) begin
            req_we_1 = bq1[0].we; req_last_1 = bq1[0].last;
            req_addr_1 = bq1[0].addr; req_wdata_1 = bq1[0].wdata;
        end
    endtask

    task automatic accept(input int id, input int t);
        beat_t    b;
        img_op_t  op;
        rsp_exp_t e;
        acc_t     a;
        b = (id == 1) ? bq1.pop_front() : bq0.pop_front();
        a.cyc = t; a.id = id;
        alog.push_back(a);
        op.we = b.we; op.addr = b.addr; op.data = b.wdata; op.cyc = t + 1;
        iq.push_back(op);
        if (b.we) begin
            shadow[b.addr] = b.wdata;
        end else begin
            e.data = shadow_rd(b.addr);
            e.cyc  = t + RD_LAT + 2;
            if (id == 1) rq1.push_back(e);
            else         rq0.push_back(e);
        end
    endtask

    // Called just after a rising edge; covers one full clock cycle.
    task automatic step();
        bit a0, a1;
        int t;
        @(negedge clk);
        a0 = req_valid_0 && req_ready_0;
        a1 = req_valid_1 && req_ready_1;
        t  = cyc;
        chk("grant_mutex", a0 && a1, 0);
        @(posedge clk);
        #1;
        if (a0) accept(0, t);
        if (a1) accept(1, t);
        drive();
    endtask

    task automatic run(input string name, input int budget);
        int n = 0;
        while ((bq0.size() + bq1.size() + rq0.size() + rq1.size() + iq.size()) != 0
               && n < budget) begin
            step();
            n++;
        end
        chk({name, "_completes"}, n < budget, 1);
        if (n >= budget) begin
            bq0.delete(); bq1.delete(); rq0.delete(); rq1.delete(); iq.delete();
            drive();
        end
        en0 = 1; en1 = 1;
        drive();
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
        rq0.delete();
        rq1.delete();
    endtask

    task automatic check_seq(input string name, input int start,
                             input int ids[$], input int offs[$]);
        chk({name, "_accepts"}, alog.size() - start, ids.size());
        for (int i = 0; i < ids.size() && start + i < alog.size(); i++) begin
            chk({name, "_grant_id"}, alog[start+i].id, ids[i]);
            chk({name, "_grant_cyc"}, alog[start+i].cyc - alog[start].cyc, offs[i]);
        end
    endtask

    initial begin
        int s, r0, r1, w0;
        int ids[$], offs[$];

        rst = 0;
        req_valid_0 = 0; req_we_0 = 0; req_last_0 = 0; req_addr_0 = '0; req_wdata_0 = '0;
        req_valid_1 = 0; req_we_1 = 0; req_last_1 = 0; req_addr_1 = '0; req_wdata_1 = '0;
        mem[17'h00010]    = 48'h1234_5678_9ABC;
        shadow[17'h00010] = 48'h1234_5678_9ABC;

        // Reset state, including ready held low while in reset.
        repeat (2) @(posedge clk);
        #1;
        req_valid_0 = 1; req_valid_1 = 1;
        @(negedge clk);
        chk("rst_ready0", req_ready_0, 0);
        chk("rst_ready1", req_ready_1, 0);
        chk("rst_img_ena", img_ena, 0);
        chk("rst_img_wea", img_wea, 0);
        chk("rst_img_addr", img_addra, 0);
        chk("rst_img_din", img_dina, 0);
        chk("rst_rsp_valid0", rsp_valid_0, 0);
        chk("rst_rsp_valid1", rsp_valid_1, 0);
        chk("rst_rsp_data0", rsp_data_0, 0);
        chk("rst_rsp_data1", rsp_data_1, 0);
        @(posedge clk);
        #1;
        rst = 1;
        mon_en = 1;
        drive();

        // Single read by requester 0.
        r1 = rsp_cnt1; s = alog.size();
        push_beat(0, 1'b0, 1'b1, 17'h00010, 48'h0);
        drive();
        run("t1", 40);
        chk("t1_rsp_data0", rsp_data_0, 48'h1234_5678_9ABC);
        chk("t1_no_rsp1", rsp_cnt1 - r1, 0);
        ids = {0}; offs = {0};
        check_seq("t1", s, ids, offs);

        // Both requesters with 4-beat bursts: 0, 1, 0 back to back.
        do_reset();
        s = alog.size(); w0 = img_cnt;
        add_burst(0, 4, 17'h00020);
        add_burst(0, 4, 17'h00024);
        add_burst(1, 4, 17'h00040);
        drive();
        run("t2", 80);
        ids.delete(); offs.delete();
        for (int i = 0; i < 12; i++) begin
            ids.push_back((i >= 4 && i < 8) ? 1 : 0);
            offs.push_back(i);
        end
        check_seq("t2", s, ids, offs);
        chk("t2_img_pulses", img_cnt - w0, 12);

        // Forced release after MAX_BURST beats without last.
        do_reset();
        s = alog.size();
        add_burst(0, 20, 17'h00100);
        add_burst(1, 3, 17'h00200);
        drive();
        run("t3", 100);
        ids.delete(); offs.delete();
        for (int i = 0; i < 23; i++) begin
            ids.push_back((i >= 16 && i < 19) ? 1 : 0);
            offs.push_back(i);
        end
        check_seq("t3", s, ids, offs);

        // Write by requester 1, read-back by requester 0 on the next cycle.
        s = alog.size(); w0 = wea_cnt;
        en0 = 0;
        push_beat(1, 1'b1, 1'b1, 17'h1FFFF, 48'hAAAA_AAAA_AAAA);
        push_beat(0, 1'b0, 1'b1, 17'h1FFFF, 48'h0);
        drive();
        step();
        en0 = 1;
        drive();
        run("t4", 40);
        chk("t4_wea_pulses", wea_cnt - w0, 1);
        chk("t4_rsp_data0", rsp_data_0, 48'hAAAA_AAAA_AAAA);
        ids = {1, 0}; offs = {0, 1};
        check_seq("t4", s, ids, offs);

        // Owner stalls after 3 beats; rr then favours requester 1, then 0.
        do_reset();
        s = alog.size();
        add_burst(0, 6, 17'h00300);
        add_burst(1, 1, 17'h00400);
        add_burst(1, 1, 17'h00401);
        drive();
        repeat (3) step();
        en0 = 0;
        drive();
        step();
        en0 = 1;
        drive();
        run("t5", 60);
        ids = {0, 0, 0, 1, 0, 0, 0, 1};
        offs = {0, 1, 2, 4, 5, 6, 7, 8};
        check_seq("t5", s, ids, offs);

        // Reset with two reads in flight.
        add_burst(0, 2, 17'h00500);
        drive();
        step();
        step();
        do_reset();
        r0 = rsp_cnt0; r1 = rsp_cnt1;
        @(negedge clk);
        chk("t6_img_ena", img_ena, 0);
        chk("t6_img_wea", img_wea, 0);
        chk("t6_img_addr", img_addra, 0);
        chk("t6_img_din", img_dina, 0);
        chk("t6_rsp_data0", rsp_data_0, 0);
        chk("t6_rsp_data1", rsp_data_1, 0);
        repeat (10) step();
        chk("t6_no_rsp", (rsp_cnt0 - r0) + (rsp_cnt1 - r1), 0);
        s = alog.size();
        push_beat(1, 1'b0, 1'b1, 17'h00055, 48'h0);
        drive();
        run("t6", 40);
        chk("t6_rsp_data1_after", rsp_data_1, 48'hC0DE_0000_0055);
        ids = {1}; offs = {0};
        check_seq("t6", s, ids, offs);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
